uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered serial transmitter that sits directly downstream of the UART register block.
- Accepts bytes written by the CPU store path, queues them in a small FIFO, and serialises them onto uart_tx as 8N1 frames.
- Reports full, busy and frame-done status back to the register block for polling and interrupt use.

Parameters:
- BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600). Legal range 2..65535.
- FIFO_DEPTH, 4, byte entries. Must be a power of 2, at least 2.
- DATA_W, 8, bits per character. Fixed at 8 for 8N1.

Ports:
- clk  in  1  system clock; every flop is clocked on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  one-cycle write strobe from the register block.
- wr_data  in  8  byte to enqueue; sampled when wr_en=1.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- tx_busy  out  1  serialiser not in IDLE.
- tx_done  out  1  one-cycle pulse at the end of each stop bit.
- ovf  out  1  one-cycle pulse when a write is dropped because the FIFO is full.
- uart_tx  out  1  serial line; idles high.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and level go to 0; empty=1, full=0.
  - State goes to IDLE and the baud counter to 0.
  - uart_tx=1; tx_busy=0, tx_done=0, ovf=0.
  - Reset mid-frame aborts the frame and drives uart_tx high immediately. Queued bytes are discarded.
- FIFO:
  - Synchronous write and read pointers, wrapping modulo FIFO_DEPTH.
  - A write is accepted only if full=0 in that cycle. Otherwise the byte is dropped and ovf pulses the next cycle.
  - Simultaneous write and pop when not full: both happen and level is unchanged.
  - Write while full and popping in the same cycle: the write is still dropped, because full is evaluated before the pop.
  - Flags and level are registered and update the cycle after the write or pop.
- Serialiser FSM, with states IDLE, START, DATA, STOP:
  - IDLE:
    - uart_tx=1.
    - If empty=0: pop the head into a shift register, clear the baud counter and bit index, and go to START.
  - START:
    - uart_tx=0 for BAUD_DIV cycles, then go to DATA.
  - DATA:
    - uart_tx=shift[0] for BAUD_DIV cycles per bit, LSB first.
    - Shift right after each bit.
    - After bit 7 go to STOP.
  - STOP:
    - uart_tx=1 for BAUD_DIV cycles.
    - On the last cycle, pulse tx_done.
    - If empty=0 on that last cycle, pop the head and go to START with no idle gap. Otherwise go to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and is cleared on every state change.
  - A bit period ends when the counter = BAUD_DIV-1.
- tx_busy = (state != IDLE).
- uart_tx is driven from a flop so the line has no glitches.
- Timing:
  - A frame lasts exactly 10*BAUD_DIV cycles.
  - Write at cycle N into an empty, idle block: empty=0 at N+1, pop at N+1, uart_tx falls at N+2.
  - tx_done pulses at cycle N+1+10*BAUD_DIV.
- Changing wr_data while wr_en=0 has no effect.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - constants FRAME_BITS=10 and DATA_BITS=8;
  - the default BAUD_DIV constant, shared with the RX path.
- Sub-module uart_sync_fifo, parameterised by DATA_W and FIFO_DEPTH:
  - ports: clk, reset, wr_en, wr_data, rd_en, rd_data, full, empty, level;
  - rd_data is the show-ahead head entry.
- The top level holds the FSM, baud counter, shift register and ovf logic.

Test Plan (BAUD_DIV=4, FIFO_DEPTH=4):
- Single byte: write 0xA5 while idle at cycle N → uart_tx falls at N+2, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high; tx_done pulses at N+41; tx_busy back to 0 at N+42.
- Burst: write 0x01,0x02,0x03,0x04 on consecutive cycles → level peaks at 3, full never asserts, four frames back-to-back with no idle cycles between stop and start, and 4 tx_done pulses spaced 40 cycles apart.
- Overflow: write 6 bytes on consecutive cycles while the first frame is in flight → the first 5 are accepted, the 6th is dropped with one ovf pulse, and exactly 5 frames go out in write order.
- Simultaneous push and pop: with level=1, write a byte on the last STOP cycle → level stays 1, the next frame starts immediately, and the new byte follows.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued → uart_tx=1, tx_busy=0 and empty=1 without waiting for a clock edge. After release, the line stays high with no frames sent.
- Wrap-around: 12 single-byte writes spaced 45 cycles apart → pointers wrap three times and every frame carries the written value.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and frame constants,
// also used by the RX path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int unsigned FRAME_BITS       = 10;
    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned BAUD_DIV_DEFAULT = 5208;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty/level flags.
// Writes while full are ignored; pops while empty are ignored.
module uart_sync_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              r_full;
    logic              r_empty;

    logic              w_push;
    logic              w_pop;
    logic [AW:0]       w_level_nxt;

    // Flags are registered, so acceptance uses last cycle's occupancy.
    assign w_push = wr_en & ~r_full;
    assign w_pop  = rd_en & ~r_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_ONE;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LVL_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_FULL);
            r_empty <= (w_level_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = r_full;
    assign empty   = r_empty;
    assign level   = r_level;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serialiser FSM that
// chains frames back to back while data is queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = DATA_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          ovf,
    output logic                          uart_tx
);

    localparam int unsigned BW = $clog2(DATA_W);
    localparam logic [15:0]   CNT_ONE  = 16'd1;
    localparam logic [15:0]   CNT_LAST = 16'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BIT_ONE  = 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [15:0]       r_cnt;
    logic [15:0]       w_cnt_nxt;
    logic [BW-1:0]     r_bit;
    logic [BW-1:0]     w_bit_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              r_ovf;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_bit_end;

    uart_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (w_rd_en),
        .rd_data (w_rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign w_bit_end = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_ONE;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_rd_en     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!empty) begin
                    w_rd_en     = 1'b1;
                    w_shift_nxt = w_rd_data;
                    w_bit_nxt   = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit + BIT_ONE;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (!empty) begin
                        w_rd_en     = 1'b1;
                        w_shift_nxt = w_rd_data;
                        w_bit_nxt   = '0;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Line level is registered from the upcoming state so uart_tx is glitch-free.
    always_comb begin
        w_tx_nxt = 1'b1;
        if (w_state_nxt == START) begin
            w_tx_nxt = 1'b0;
        end else if (w_state_nxt == DATA) begin
            w_tx_nxt = w_shift_nxt[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_ovf   <= wr_en & full;
        end
    end

    assign uart_tx = r_tx;
    assign tx_busy = (r_state != IDLE);
    assign tx_done = (r_state == STOP) && w_bit_end;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BAUD_DIV=4, FIFO_DEPTH=4; a line
// receiver collects transmitted bytes for comparison against written data.
module tb_uart_tx_fifo;

    localparam int B = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, tx_busy, tx_done, ovf, uart_tx;
    logic [2:0] level;

    int n_checks = 0;
    int n_fail = 0;
    int rx_ferr = 0;
    int rst_cnt = 0;
    logic [7:0] rxq[$];

    uart_tx_fifo #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (4),
        .DATA_W     (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .ovf     (ovf),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    always @(negedge reset) rst_cnt++;

    // Line receiver: samples mid-bit, drops any frame interrupted by reset.
    initial begin
        logic       prev;
        logic [7:0] b;
        logic       ok;
        int         rs;
        prev = 1'b1;
        b = 8'h00;
        forever begin
            @(posedge clk); #2;
            if (!reset) begin
                prev = 1'b1;
            end else if (prev && !uart_tx) begin
                ok = 1'b1;
                rs = rst_cnt;
                repeat (2) @(posedge clk);
                #2;
                if (uart_tx) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(posedge clk);
                    #2;
                    b[i] = uart_tx;
                end
                repeat (B) @(posedge clk);
                #2;
                if (rs != rst_cnt || !reset) ok = 1'b0;
                if (ok && !uart_tx) rx_ferr++;
                if (ok) rxq.push_back(b);
                prev = 1'b1;
            end else begin
                prev = uart_tx;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_uart_tx: got %b want 1", uart_tx); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_tx_busy: got %b want 0", tx_busy); end
        n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL rst_tx_done: got %b want 0", tx_done); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", level); end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) tick();
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_idle_line: got %b want 1", uart_tx); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b want 0", tx_busy); end
    endtask

    task automatic test_single_byte();
        logic [7:0] v;
        logic       exp_tx;
        int         pos;
        v = 8'hA5;
        rxq.delete();
        wr_en = 1'b1; wr_data = v;
        tick();
        wr_en = 1'b0; wr_data = 8'hFF;
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty_n1: got %b want 0", empty); end
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_n1: got %b want 1", uart_tx); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_n1: got %b want 0", tx_busy); end
        tick();
        for (int k = 0; k < 10 * B; k++) begin
            pos = k / B;
            if (pos == 0) exp_tx = 1'b0;
            else if (pos <= 8) exp_tx = v[pos-1];
            else exp_tx = 1'b1;
            n_checks++; if (uart_tx !== exp_tx) begin n_fail++; $display("FAIL single_line k=%0d: got %b want %b", k, uart_tx, exp_tx); end
            n_checks++; if (tx_done !== (k == 10 * B - 1)) begin n_fail++; $display("FAIL single_done k=%0d: got %b want %b", k, tx_done, (k == 10 * B - 1)); end
            n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy k=%0d: got %b want 1", k, tx_busy); end
            tick();
        end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", tx_busy); end
        n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL single_done_end: got %b want 0", tx_done); end
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL single_line_end: got %b want 1", uart_tx); end
        n_checks++; if (rxq.size() !== 1) begin n_fail++; $display("FAIL single_rx_count: got %0d want 1", rxq.size()); end
        else begin
            n_checks++; if (rxq[0] !== v) begin n_fail++; $display("FAIL single_rx_byte: got %h want %h", rxq[0], v); end
        end
        repeat (3) tick();
    endtask

    task automatic test_burst();
        int peak, full_seen, ndone, gaps, t;
        int done_t[4];
        logic [7:0] exp_b;
        peak = 0; full_seen = 0; ndone = 0; gaps = 0;
        rxq.delete();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            if (int'(level) > peak) peak = int'(level);
            if (full) full_seen++;
            tick();
        end
        wr_en = 1'b0;
        for (t = 0; t < 250 && ndone < 4; t++) begin
            if (int'(level) > peak) peak = int'(level);
            if (full) full_seen++;
            if (!tx_busy) gaps++;
            if (tx_done) begin done_t[ndone] = t; ndone++; end
            tick();
        end
        n_checks++; if (peak !== 3) begin n_fail++; $display("FAIL burst_level_peak: got %0d want 3", peak); end
        n_checks++; if (full_seen !== 0) begin n_fail++; $display("FAIL burst_full: got %0d cycles full want 0", full_seen); end
        n_checks++; if (ndone !== 4) begin n_fail++; $display("FAIL burst_done_count: got %0d want 4", ndone); end
        else begin
            for (int i = 1; i < 4; i++) begin
                n_checks++; if (done_t[i] - done_t[i-1] !== 10 * B) begin n_fail++; $display("FAIL burst_done_spacing %0d: got %0d want %0d", i, done_t[i] - done_t[i-1], 10 * B); end
            end
        end
        n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL burst_idle_gap: got %0d idle cycles want 0", gaps); end
        tick();
        n_checks++; if (rxq.size() !== 4) begin n_fail++; $display("FAIL burst_rx_count: got %0d want 4", rxq.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                exp_b = 8'(i + 1);
                n_checks++; if (rxq[i] !== exp_b) begin n_fail++; $display("FAIL burst_rx_byte %0d: got %h want %h", i, rxq[i], exp_b); end
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_overflow();
        int ovf_cnt, ovf_idx, ndone;
        logic full_at5;
        logic [7:0] exp_b;
        ovf_cnt = 0; ovf_idx = -1; ndone = 0; full_at5 = 1'b0;
        rxq.delete();
        for (int i = 0; i < 11; i++) begin
            if (i < 6) begin wr_en = 1'b1; wr_data = 8'(8'h11 + i); end
            else wr_en = 1'b0;
            if (i == 5) full_at5 = full;
            if (ovf) begin ovf_cnt++; ovf_idx = i; end
            if (tx_done) ndone++;
            tick();
        end
        n_checks++; if (full_at5 !== 1'b1) begin n_fail++; $display("FAIL ovf_full_at_6th: got %b want 1", full_at5); end
        n_checks++; if (ovf_cnt !== 1) begin n_fail++; $display("FAIL ovf_pulse_count: got %0d want 1", ovf_cnt); end
        n_checks++; if (ovf_idx !== 6) begin n_fail++; $display("FAIL ovf_pulse_cycle: got %0d want 6", ovf_idx); end
        for (int t = 0; t < 300 && ndone < 5; t++) begin
            if (tx_done) ndone++;
            tick();
        end
        n_checks++; if (ndone !== 5) begin n_fail++; $display("FAIL ovf_done_count: got %0d want 5", ndone); end
        repeat (4) tick();
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_end: got %b want 0", tx_busy); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty_end: got %b want 1", empty); end
        n_checks++; if (rxq.size() !== 5) begin n_fail++; $display("FAIL ovf_rx_count: got %0d want 5", rxq.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                exp_b = 8'(8'h11 + i);
                n_checks++; if (rxq[i] !== exp_b) begin n_fail++; $display("FAIL ovf_rx_byte %0d: got %h want %h", i, rxq[i], exp_b); end
            end
        end
    endtask

    task automatic test_push_pop();
        int found, ndone;
        found = 0; ndone = 0;
        rxq.delete();
        wr_en = 1'b1; wr_data = 8'h5A; tick();
        wr_data = 8'hC3; tick();
        wr_en = 1'b0;
        n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL pp_level_pre: got %0d want 1", level); end
        for (int t = 0; t < 60 && found == 0; t++) begin
            if (tx_done) found = 1;
            else tick();
        end
        n_checks++; if (found !== 1) begin n_fail++; $display("FAIL pp_first_done: got %0d want 1", found); end
        wr_en = 1'b1; wr_data = 8'h3C; tick();
        wr_en = 1'b0;
        n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL pp_level_post: got %0d want 1", level); end
        n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL pp_next_start: got %b want 0", uart_tx); end
        n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL pp_busy: got %b want 1", tx_busy); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL pp_ovf: got %b want 0", ovf); end
        for (int t = 0; t < 120 && ndone < 2; t++) begin
            if (tx_done) ndone++;
            tick();
        end
        n_checks++; if (ndone !== 2) begin n_fail++; $display("FAIL pp_done_count: got %0d want 2", ndone); end
        tick();
        n_checks++; if (rxq.size() !== 3) begin n_fail++; $display("FAIL pp_rx_count: got %0d want 3", rxq.size()); end
        else begin
            n_checks++; if (rxq[0] !== 8'h5A) begin n_fail++; $display("FAIL pp_rx0: got %h want 5a", rxq[0]); end
            n_checks++; if (rxq[1] !== 8'hC3) begin n_fail++; $display("FAIL pp_rx1: got %h want c3", rxq[1]); end
            n_checks++; if (rxq[2] !== 8'h3C) begin n_fail++; $display("FAIL pp_rx2: got %h want 3c", rxq[2]); end
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_midframe();
        int highs, busy_seen, done_seen;
        highs = 0; busy_seen = 0; done_seen = 0;
        rxq.delete();
        wr_en = 1'b1; wr_data = 8'h81; tick();
        wr_data = 8'h42; tick();
        wr_data = 8'h24; tick();
        wr_en = 1'b0;
        // now at write+3; bit 3 of the data field spans offsets 16..19 from start
        repeat (16) tick();
        n_checks++; if (level !== 3'd2) begin n_fail++; $display("FAIL mid_level_pre: got %0d want 2", level); end
        n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %b want 1", tx_busy); end
        #3 reset = 1'b0;
        #1;
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL mid_rst_line: got %b want 1", uart_tx); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", tx_busy); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty: got %b want 1", empty); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL mid_rst_level: got %0d want 0", level); end
        repeat (3) tick();
        reset = 1'b1;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (uart_tx) highs++;
            if (tx_busy) busy_seen++;
            if (tx_done) done_seen++;
        end
        n_checks++; if (highs !== 100) begin n_fail++; $display("FAIL mid_line_high: got %0d high cycles want 100", highs); end
        n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL mid_busy_after: got %0d want 0", busy_seen); end
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL mid_done_after: got %0d want 0", done_seen); end
        n_checks++; if (rxq.size() !== 0) begin n_fail++; $display("FAIL mid_rx_count: got %0d want 0", rxq.size()); end
    endtask

    task automatic test_wrap();
        logic [7:0] vals[12];
        int ndone;
        ndone = 0;
        rxq.delete();
        for (int i = 0; i < 12; i++) begin
            vals[i] = 8'((i * 37 + 5) % 256);
            wr_en = 1'b1; wr_data = vals[i];
            tick();
            wr_en = 1'b0;
            for (int t = 0; t < 44; t++) begin
                wr_data = 8'($urandom_range(255));
                if (tx_done) ndone++;
                tick();
            end
        end
        repeat (5) tick();
        n_checks++; if (ndone !== 12) begin n_fail++; $display("FAIL wrap_done_count: got %0d want 12", ndone); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", empty); end
        n_checks++; if (rxq.size() !== 12) begin n_fail++; $display("FAIL wrap_rx_count: got %0d want 12", rxq.size()); end
        else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++; if (rxq[i] !== vals[i]) begin n_fail++; $display("FAIL wrap_rx_byte %0d: got %h want %h", i, rxq[i], vals[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_push_pop();
        test_reset_midframe();
        test_wrap();
        n_checks++; if (rx_ferr !== 0) begin n_fail++; $display("FAIL stop_bits: got %0d framing errors want 0", rx_ferr); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
